// File: rtl/bin2bcd_seq16_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encodings, default sizing and the per-digit adjust rule.
package bin2bcd_seq16_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    // S_DONE keeps the same encoding used by the other multi-cycle display helpers
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Double-dabble correction: a digit of 5 or more would become >= 10 after
    // the next doubling, so add 3 now so that the carry lands in the next nibble
    function automatic logic [3:0] adjust_nibble(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
    endfunction

endpackage

// File: rtl/bin2bcd_seq16_bcd_digit_adj.sv
// One BCD digit's add-3 correction slice, applied before every shift.
module bcd_digit_adj
    import bin2bcd_seq16_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Purely combinational correction of a single nibble
    always_comb begin
        dout = adjust_nibble(din);
    end

endmodule

// File: rtl/bin2bcd_seq16.sv
// Sequential shift-and-add-3 binary-to-BCD converter. One conversion takes
// WIDTH shift cycles plus a DONE cycle that publishes the result; bcd only
// changes on that DONE cycle so downstream digit decoders never see partials.
module bin2bcd_seq16
    import bin2bcd_seq16_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + WIDTH;
    localparam int ITER_W = $clog2(WIDTH + 1);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(WIDTH);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

    state_t              state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [SR_W-1:0]     sr_adj;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                done_q, done_d;

    // The binary part passes through untouched; only the BCD nibbles are adjusted
    assign sr_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .din  (sr_q[WIDTH + 4*g +: 4]),
            .dout (sr_adj[WIDTH + 4*g +: 4])
        );
    end

    // Next-state logic: load on accepted start, adjust-and-shift while converting,
    // publish the BCD field and pulse done for one cycle at the end
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, bin};
                    iter_d  = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                sr_d   = sr_adj << 1;
                iter_d = (iter_q != ITER_MAX) ? (iter_q + ITER_ONE) : iter_q;
                if (iter_q == ITER_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = sr_q[SR_W-1 -: BCD_W];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any conversion in flight without a done pulse
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq16.sv
// Self-checking bench for bin2bcd_seq16: directed scenarios plus random
// vectors compared against a decimal-arithmetic reference.
module tb_bin2bcd_seq16;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] bin      = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    bin2bcd_seq16 dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd)
    );

    // Free-running 100 MHz-style clock
    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference: digit k is (value / 10**k) % 10
    function automatic logic [19:0] refBcd(input int value);
        logic [19:0] r;
        int div;
        r   = '0;
        div = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((value / div) % 10);
            div = div * 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle with the given value, then wait for done (bounded)
    task automatic applyStimulus(input logic [15:0] value, output int latency,
                                 output int busyCycles);
        bin   = value;
        start = 1'b1;
        @(negedge CLOCK_50);
        start      = 1'b0;
        busyCycles = busy ? 1 : 0;
        latency    = 0;
        while (!done && latency < 40) begin
            @(negedge CLOCK_50);
            latency++;
            if (busy) busyCycles++;
        end
    endtask

    initial begin
        int lat, bcyc, doneCount, cyc, firstDone, secondDone, unstable;
        logic [19:0] seenBcd, firstBcd, secondBcd;
        logic [15:0] v;

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_bcd", 32'(bcd), 32'd0);

        // Zero input: latency 17, busy 17 cycles, single-cycle done
        applyStimulus(16'd0, lat, bcyc);
        checkOutput("zero_latency", 32'(lat), 32'd17);
        checkOutput("zero_busy_cycles", 32'(bcyc), 32'd17);
        checkOutput("zero_bcd", 32'(bcd), 32'(refBcd(0)));
        @(negedge CLOCK_50);
        checkOutput("zero_done_one_cycle", 32'(done), 32'd0);

        // Boundary and typical values
        applyStimulus(16'hFFFF, lat, bcyc);
        checkOutput("max_bcd", 32'(bcd), 32'h65535);
        checkOutput("max_latency", 32'(lat), 32'd17);
        applyStimulus(16'd12345, lat, bcyc);
        checkOutput("12345_bcd", 32'(bcd), 32'(refBcd(12345)));
        applyStimulus(16'd9, lat, bcyc);
        checkOutput("9_bcd", 32'(bcd), 32'h00009);
        @(negedge CLOCK_50);

        // Start while busy is ignored, bin changes after acceptance do not matter
        bin   = 16'd100;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        bin   = 16'd7;
        start = 1'b1;
        @(negedge CLOCK_50);
        start     = 1'b0;
        doneCount = 0;
        seenBcd   = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (done) begin
                doneCount++;
                seenBcd = bcd;
            end
        end
        checkOutput("busy_start_done_count", 32'(doneCount), 32'd1);
        checkOutput("busy_start_bcd", 32'(seenBcd), 32'h00100);

        // Reset mid-conversion aborts without a done pulse
        bin   = 16'd4321;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_bcd", 32'(bcd), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLOCK_50);
            if (done) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        applyStimulus(16'd42, lat, bcyc);
        checkOutput("after_abort_bcd", 32'(bcd), 32'h00042);
        @(negedge CLOCK_50);

        // Reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("reset_beats_start", 32'(busy), 32'd0);
        @(negedge CLOCK_50);

        // Start held high: back-to-back conversions, period 18, bcd stable between
        bin        = 16'd9;
        start      = 1'b1;
        firstDone  = -1;
        secondDone = -1;
        firstBcd   = '0;
        secondBcd  = '0;
        unstable   = 0;
        for (cyc = 0; cyc < 60 && secondDone < 0; cyc++) begin
            @(negedge CLOCK_50);
            if (done) begin
                if (firstDone < 0) begin
                    firstDone = cyc;
                    firstBcd  = bcd;
                    bin       = 16'd10;
                end else begin
                    secondDone = cyc;
                    secondBcd  = bcd;
                    start      = 1'b0;
                end
            end else if (firstDone >= 0 && bcd !== firstBcd) begin
                unstable++;
            end
        end
        start = 1'b0;
        checkOutput("held_period", 32'(secondDone - firstDone), 32'd18);
        checkOutput("held_first_bcd", 32'(firstBcd), 32'h00009);
        checkOutput("held_second_bcd", 32'(secondBcd), 32'h00010);
        checkOutput("held_bcd_stable", 32'(unstable), 32'd0);
        repeat (2) @(negedge CLOCK_50);
        checkOutput("held_release_idle", 32'(busy), 32'd0);

        // Random vectors against the decimal reference
        for (int n = 0; n < 1000; n++) begin
            v = 16'($urandom_range(0, 65535));
            applyStimulus(v, lat, bcyc);
            checkOutput("rand_latency", 32'(lat), 32'd17);
            checkOutput("rand_bcd", 32'(bcd), 32'(refBcd(int'(v))));
            @(negedge CLOCK_50);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
